// File: rtl/err_compute_sm.sv
`default_nettype none
// ============================================================================
// Module  : err_compute_sm
// Brief   : Sequencer for the error-compute datapath. It clears the
//           accumulator, steps sel through the 8 IR channels and pulses
//           err_vld when the sum is final. Optional macro ERR_RESTART_EN
//           lets IR_vld restart a sequence that is in SETTLE or ACCUM.
// Revision: 1.0 - initial release
// ============================================================================
module err_compute_sm #(
    parameter int SETTLE_CYC = 0,
    parameter bit SUB_LEFT   = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       IR_vld,
    output logic [2:0] sel,
    output logic       sub,
    output logic       en_accum,
    output logic       clr_accum,
    output logic       busy,
    output logic       err_vld
);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_CLR    = 3'd1;
    localparam logic [2:0] c_SETTLE = 3'd2;
    localparam logic [2:0] c_ACCUM  = 3'd3;
    localparam logic [2:0] c_DONE   = 3'd4;

    localparam bit         c_HAS_SETTLE  = (SETTLE_CYC > 0);
    localparam logic [3:0] c_SETTLE_LAST = 4'(SETTLE_CYC - 1);
    localparam logic [2:0] c_AFTER_STEP  = c_HAS_SETTLE ? c_SETTLE : c_ACCUM;

    logic [2:0] r_state;
    logic [2:0] r_sel;
    logic [3:0] r_cnt;
    logic       w_restart;
    logic       w_sub_raw;

`ifdef ERR_RESTART_EN
    assign w_restart = IR_vld && ((r_state == c_SETTLE) || (r_state == c_ACCUM));
`else
    assign w_restart = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_sel   <= 3'd0;
            r_cnt   <= 4'd0;
        end else if (w_restart) begin
            r_state <= c_CLR;
            r_sel   <= 3'd0;
            r_cnt   <= 4'd0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (IR_vld) begin
                        r_state <= c_CLR;
                        r_sel   <= 3'd0;
                        r_cnt   <= 4'd0;
                    end
                end
                c_CLR: begin
                    r_state <= c_AFTER_STEP;
                end
                c_SETTLE: begin
                    if (r_cnt == c_SETTLE_LAST) begin
                        r_cnt   <= 4'd0;
                        r_state <= c_ACCUM;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                c_ACCUM: begin
                    // Channel 7 is the last operand; sel parks at 0 for the next run
                    if (r_sel == 3'd7) begin
                        r_sel   <= 3'd0;
                        r_state <= c_DONE;
                    end else begin
                        r_sel   <= r_sel + 3'd1;
                        r_state <= c_AFTER_STEP;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_sel   <= 3'd0;
                    r_cnt   <= 4'd0;
                end
            endcase
        end
    end

    generate
        if (SUB_LEFT) begin : g_sub_left
            assign w_sub_raw = r_sel[0];
        end else begin : g_sub_right
            assign w_sub_raw = ~r_sel[0];
        end
    endgenerate

    assign sel       = r_sel;
    assign sub       = w_sub_raw && ((r_state == c_SETTLE) || (r_state == c_ACCUM));
    assign en_accum  = (r_state == c_ACCUM);
    assign clr_accum = (r_state == c_CLR);
    assign busy      = (r_state != c_IDLE);
    assign err_vld   = (r_state == c_DONE);

endmodule
`default_nettype wire

// File: tb/tb_err_compute_sm.sv
`default_nettype none
// ============================================================================
// Module  : tb_err_compute_sm
// Brief   : Scoreboard bench for err_compute_sm; two instances (SETTLE_CYC=0
//           with SUB_LEFT=1, SETTLE_CYC=2 with SUB_LEFT=0) share stimulus.
// Revision: 1.0 - initial release
// ============================================================================
module tb_err_compute_sm;

    logic       clk;
    logic       rst_n;
    logic       IR_vld;
    logic [2:0] sel0, sel2;
    logic       sub0, en0, clr0, busy0, err0;
    logic       sub2, en2, clr2, busy2, err2;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] q0[$];
    logic [7:0] q2[$];

    err_compute_sm #(.SETTLE_CYC(0), .SUB_LEFT(1'b1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .sel(sel0), .sub(sub0),
        .en_accum(en0), .clr_accum(clr0), .busy(busy0), .err_vld(err0)
    );

    err_compute_sm #(.SETTLE_CYC(2), .SUB_LEFT(1'b0)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .IR_vld(IR_vld), .sel(sel2), .sub(sub2),
        .en_accum(en2), .clr_accum(clr2), .busy(busy2), .err_vld(err2)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Expected {sel, sub, en_accum, clr_accum, busy, err_vld} p cycles after the
    // edge that started a sequence (p=0 is the clear cycle).
    function automatic logic [7:0] exp_out(bit act, int p, int s, bit sl);
        logic [7:0] v;
        logic [2:0] sel_v;
        int         i;
        int         r;
        v = 8'h00;
        if (act && p >= 0 && p <= 9 + 8 * s) begin
            if (p == 0) begin
                v = {3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
            end else if (p == 9 + 8 * s) begin
                v = {3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
            end else begin
                i     = (p - 1) / (s + 1);
                r     = (p - 1) % (s + 1);
                sel_v = 3'(i);
                v     = {sel_v, (sl ? sel_v[0] : ~sel_v[0]), (r == s), 1'b0, 1'b1, 1'b0};
            end
        end
        return v;
    endfunction

    int e = 0;
    bit act0 = 1'b0;
    bit act2 = 1'b0;
    int st0 = 0;
    int st2 = 0;

    task automatic upd(inout bit act, inout int st, input int s);
        int pp;
        bit bsy;
        if (!rst_n) begin
            act = 1'b0;
        end else begin
            pp  = e - 1 - st;
            bsy = act && (pp <= 9 + 8 * s);
            if (IR_vld) begin
                if (!bsy) begin
                    act = 1'b1;
                    st  = e;
                end
`ifdef ERR_RESTART_EN
                else if (pp >= 1 && pp <= 8 + 8 * s) begin
                    st = e;
                end
`endif
            end
        end
    endtask

    // Reference model: samples the inputs at each rising edge and queues the response
    initial begin
        forever begin
            @(posedge clk);
            e = e + 1;
            upd(act0, st0, 0);
            upd(act2, st2, 2);
            q0.push_back(exp_out(act0, e - st0, 0, 1'b1));
            q2.push_back(exp_out(act2, e - st2, 2, 1'b0));
        end
    end

    // Monitor: compares every presented output cycle against the queue head
    initial begin
        logic [7:0] exp_v;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                exp_v = q0.pop_front();
                got   = {sel0, sub0, en0, clr0, busy0, err0};
                n_vec = n_vec + 1;
                if (got !== exp_v) begin
                    n_err = n_err + 1;
                    $display("FAIL s0_outputs t=%0t got=%b exp=%b (sel,sub,en,clr,busy,err)", $time, got, exp_v);
                end
            end
            if (q2.size() > 0) begin
                exp_v = q2.pop_front();
                got   = {sel2, sub2, en2, clr2, busy2, err2};
                n_vec = n_vec + 1;
                if (got !== exp_v) begin
                    n_err = n_err + 1;
                    $display("FAIL s2_outputs t=%0t got=%b exp=%b (sel,sub,en,clr,busy,err)", $time, got, exp_v);
                end
            end
        end
    end

    task automatic drive(input logic v);
        @(negedge clk);
        #2;
        IR_vld = v;
    endtask

    // Asynchronous reset pulse: outputs must clear before any clock edge
    task automatic pulse_reset(input int len);
        logic [15:0] got;
        @(negedge clk);
        #2;
        rst_n  = 1'b0;
        IR_vld = 1'b0;
        #1;
        got   = {sel0, sub0, en0, clr0, busy0, err0, sel2, sub2, en2, clr2, busy2, err2};
        n_vec = n_vec + 1;
        if (got !== 16'h0000) begin
            n_err = n_err + 1;
            $display("FAIL async_reset t=%0t got=%h exp=0000", $time, got);
        end
        repeat (len) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        IR_vld = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b1;
        repeat (20) drive(1'b0);

        // single clean sequence
        drive(1'b1);
        repeat (40) drive(1'b0);

        // re-pulse while the S=0 instance is accumulating sel=4
        drive(1'b1);
        repeat (5) drive(1'b0);
        drive(1'b1);
        repeat (45) drive(1'b0);

        // reset mid-sequence, then a full normal sequence
        drive(1'b1);
        repeat (4) drive(1'b0);
        pulse_reset(2);
        drive(1'b1);
        repeat (40) drive(1'b0);

        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 299) == 0) begin
                pulse_reset(int'($urandom_range(1, 3)));
            end else begin
                drive(logic'($urandom_range(0, 9) == 0));
            end
        end
        repeat (40) drive(1'b0);

        repeat (3) @(negedge clk);
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
